wasm_operand_stack: RTL and testbench
=====================================

# wasm_operand_stack

Parametrised LIFO operand stack for the WASM execution pipeline, succeeding the fixed single-push/single-pop stack. It supports a push and a pop of 0, 1 or 2 entries in the same cycle, which covers WASM binary ops (pop 2, push 1) in one clock. It also provides combinational peek of the top two entries, full/empty flags, an occupancy count, sticky overflow/underflow errors, and a synchronous flush. It sits between the decoder/ALU and the control-flow unit, which uses `flush` on function return and trap.

## Interface
- `ST_WIDTH`, 64: entry width in bits.
- `DEPTH`, 64: number of entries; power of two, ≥ 4.
- `CNT_W`, `$clog2(DEPTH+1)`: derived local parameter, width of `count`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear of stack and errors.
- `push`  in  1  write `push_data` as the new top this cycle.
- `push_data`  in  ST_WIDTH  data to push.
- `pop_n`  in  2  entries to discard this cycle: 0, 1 or 2. Value 3 is illegal and treated as underflow.
- `top0`  out  ST_WIDTH  current top entry; 0 when `count` < 1.
- `top1`  out  ST_WIDTH  entry below the top; 0 when `count` < 2.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `isEmpty`  out  1  `count` == 0.
- `isFull`  out  1  `count` == DEPTH.
- `err_overflow`  out  1  sticky; set by a rejected operation that would exceed DEPTH.
- `err_underflow`  out  1  sticky; set by a rejected operation with `pop_n` > `count`.

## Operation
- State: storage array `mem[DEPTH]`, stack pointer `sp` (equal to `count`), and two sticky error bits.
- Reset values: `sp` = 0, both errors 0, `count` = 0, `isEmpty` = 1, `isFull` = 0, `top0` = `top1` = 0. `mem` contents are not reset.
- Priority per cycle: `flush` first, then underflow check, then overflow check, then normal update.
- `flush` = 1: `sp` becomes 0 and both errors clear. `push`/`pop_n` are ignored that cycle.
- Underflow: `pop_n` > `sp`, or `pop_n` == 3. The whole operation is dropped, including any push. `sp` and `mem` are unchanged and `err_underflow` is set.
- Overflow: `sp` − `pop_n` + `push` > DEPTH. The operation is dropped and `err_overflow` is set.
- Normal update: `sp_next` = `sp` − `pop_n` + `push`. If `push`, then `mem[sp − pop_n]` ← `push_data`.
  - Push with pop 1 overwrites the top in place.
  - Push with pop 2 writes into slot `sp−2`.
- Arithmetic is done at CNT_W+1 bits so `sp − pop_n` never wraps.
- Errors stay set until `flush` or reset. A set error bit does not block later legal operations.
- A push when `isFull` with `pop_n` ≥ 1 is legal: net occupancy ≤ DEPTH.

## Timing
- All updates are registered. New `count`, flags and tops are visible the cycle after the edge that applies the operation.
- `top0` = `mem[sp−1]` and `top1` = `mem[sp−2]` are combinational reads of registered state. They carry no dependency on this cycle's inputs, so there is no input-to-output combinational path.
- Throughput: one operation per cycle with no stalls and no handshake. The caller checks `count`/`isFull` before issuing.
- Error bits rise in the cycle after the offending edge.
- Asserting `rst_n` low mid-operation clears state immediately, regardless of `clk`. The first legal operation is taken on the first rising edge after deassertion.

## Structure
- Shared package `wasm_stack_pkg`:
  - `ST_WIDTH_DEF` = 64.
  - `pop_n` encodings: `POP_NONE`, `POP_ONE`, `POP_TWO`.
  - Typedef `st_word_t`.
- One sub-module: `stack_regfile`, with one synchronous write port and two asynchronous read ports (`raddr0`, `raddr1`). Parametrised on ST_WIDTH/DEPTH.
- The top level holds the pointer/error logic only. No FSM is needed beyond the pointer and sticky bits.

## Test plan
- Reset, then push `A5A5A5A5A5A5A5A5` and push `7B7B7B7B7B7B7B7B` → `count` = 2, `top0` = 7B…, `top1` = A5…, `isEmpty` = 0.
- From that state, one cycle with `push` = 1, `push_data` = `0000000000000010`, `pop_n` = 2 → `count` = 1, `top0` = `…0010`, `top1` = 0.
- From empty, `pop_n` = 1 → operation dropped, `count` = 0, `err_underflow` = 1. Then push `9999999999999999` → accepted, `count` = 1, error still 1.
- Fill to DEPTH (values 1..DEPTH) → `isFull` = 1, `top0` = DEPTH. Another push → dropped, `err_overflow` = 1. Push with `pop_n` = 1 of `FFFF…` → accepted, `count` = DEPTH, `top0` = `FFFF…`.
- `flush` asserted with `push` = 1 on a stack with 5 entries and both errors set → `count` = 0, errors 0, `isEmpty` = 1, and the push is ignored.
- Drive `rst_n` low between clock edges with 3 entries on the stack → outputs go to reset values without waiting for a clock edge. After release, one push gives `count` = 1.

Source files
------------

// File: rtl/wasm_stack_pkg.sv
// Shared types and constants for the WASM operand stack and its register file.
package wasm_stack_pkg;

    localparam int ST_WIDTH_DEF = 64;

    // Encodings of pop_n; the fourth code (3) is illegal and rejected as underflow.
    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    typedef logic [ST_WIDTH_DEF-1:0] st_word_t;

    // Per-cycle decision taken by the pointer logic.
    typedef struct packed {
        logic uf;
        logic of;
        logic upd;
        logic we;
    } op_dec_t;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module stack_regfile
    import wasm_stack_pkg::*;
#(
    parameter  int ST_WIDTH = ST_WIDTH_DEF,
    parameter  int DEPTH    = 64,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [ST_WIDTH-1:0] wdata,
    input  logic [AW-1:0]       raddr0,
    input  logic [AW-1:0]       raddr1,
    output logic [ST_WIDTH-1:0] rdata0,
    output logic [ST_WIDTH-1:0] rdata1
);

    logic [ST_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; occupancy is tracked by the pointer.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/wasm_operand_stack.sv
// LIFO operand stack with 0-2 pops plus an optional push per cycle, peek of top two,
// occupancy flags, sticky overflow/underflow errors and synchronous flush.
module wasm_operand_stack
    import wasm_stack_pkg::*;
#(
    parameter  int ST_WIDTH = ST_WIDTH_DEF,
    parameter  int DEPTH    = 64,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                push,
    input  logic [ST_WIDTH-1:0] push_data,
    input  logic [1:0]          pop_n,
    output logic [ST_WIDTH-1:0] top0,
    output logic [ST_WIDTH-1:0] top1,
    output logic [CNT_W-1:0]    count,
    output logic                isEmpty,
    output logic                isFull,
    output logic                err_overflow,
    output logic                err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int XW = CNT_W + 1;

    logic [CNT_W-1:0]    sp;
    logic [XW-1:0]       sp_x, pop_x, base_x, nxt_x;
    logic [AW-1:0]       waddr, raddr0, raddr1;
    logic [ST_WIDTH-1:0] rdata0, rdata1;
    op_dec_t             dec;

    // One extra bit of headroom so sp - pop_n cannot wrap before the underflow test.
    assign sp_x   = XW'(sp);
    assign pop_x  = XW'(pop_n);
    assign base_x = sp_x - pop_x;
    assign nxt_x  = base_x + XW'(push);

    always_comb begin
        dec     = '0;
        dec.uf  = !flush && ((pop_n > 2'(POP_TWO)) || (pop_x > sp_x));
        dec.of  = !flush && !dec.uf && (nxt_x > XW'(DEPTH));
        dec.upd = !flush && !dec.uf && !dec.of;
        dec.we  = dec.upd && push;
    end

    // Modulo-AW arithmetic matches sp - pop_n whenever a write is actually allowed.
    assign waddr  = AW'(sp) - AW'(pop_n);
    assign raddr0 = AW'(sp) - AW'(1);
    assign raddr1 = AW'(sp) - AW'(2);

    stack_regfile #(
        .ST_WIDTH (ST_WIDTH),
        .DEPTH    (DEPTH)
    ) u_regfile (
        .clk    (clk),
        .we     (dec.we),
        .waddr  (waddr),
        .wdata  (push_data),
        .raddr0 (raddr0),
        .raddr1 (raddr1),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp            <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            sp            <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (dec.uf) err_underflow <= 1'b1;
            if (dec.of) err_overflow  <= 1'b1;
            if (dec.upd) sp <= nxt_x[CNT_W-1:0];
        end
    end

    assign count   = sp;
    assign isEmpty = (sp == '0);
    assign isFull  = (sp == CNT_W'(DEPTH));
    assign top0    = (sp >= CNT_W'(1)) ? rdata0 : '0;
    assign top1    = (sp >= CNT_W'(2)) ? rdata1 : '0;

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Randomized and directed checks of wasm_operand_stack against a queue-based LIFO model.
module tb_wasm_operand_stack;
    import wasm_stack_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             push = 1'b0;
    st_word_t         push_data = '0;
    logic [1:0]       pop_n = 2'd0;
    st_word_t         top0, top1;
    logic [CNT_W-1:0] count;
    logic             isEmpty, isFull, err_overflow, err_underflow;

    int errors = 0;
    int checks = 0;

    st_word_t q[$];
    logic     m_uf = 1'b0;
    logic     m_of = 1'b0;

    wasm_operand_stack #(.ST_WIDTH(ST_WIDTH_DEF), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .push_data(push_data),
        .pop_n(pop_n), .top0(top0), .top1(top1), .count(count), .isEmpty(isEmpty),
        .isFull(isFull), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one operation across one rising edge and advance the reference model.
    task automatic apply(input logic f, input logic p, input st_word_t d, input logic [1:0] pn);
        flush = f; push = p; push_data = d; pop_n = pn;
        @(posedge clk); #1;
        flush = 1'b0; push = 1'b0; pop_n = 2'd0;
        if (f) begin
            q.delete(); m_uf = 1'b0; m_of = 1'b0;
        end else if (pn == 2'd3 || int'(pn) > q.size()) begin
            m_uf = 1'b1;
        end else if (q.size() - int'(pn) + int'(p) > DEPTH) begin
            m_of = 1'b1;
        end else begin
            repeat (int'(pn)) void'(q.pop_back());
            if (p) q.push_back(d);
        end
    endtask

    task automatic test_reset();
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (isEmpty !== 1'b1 || isFull !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", isEmpty, isFull); end
        checks++; if (top0 !== '0 || top1 !== '0) begin errors++; $display("FAIL reset_tops: got %h %h want 0 0", top0, top1); end
        checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL reset_errs: got of=%b uf=%b want 0 0", err_overflow, err_underflow); end
    endtask

    task automatic test_push_pair();
        apply(0, 1, 64'hA5A5A5A5A5A5A5A5, POP_NONE);
        apply(0, 1, 64'h7B7B7B7B7B7B7B7B, POP_NONE);
        checks++; if (count !== CNT_W'(2)) begin errors++; $display("FAIL push_pair_count: got %0d want 2", count); end
        checks++; if (top0 !== 64'h7B7B7B7B7B7B7B7B) begin errors++; $display("FAIL push_pair_top0: got %h want 7b7b7b7b7b7b7b7b", top0); end
        checks++; if (top1 !== 64'hA5A5A5A5A5A5A5A5) begin errors++; $display("FAIL push_pair_top1: got %h want a5a5a5a5a5a5a5a5", top1); end
        checks++; if (isEmpty !== 1'b0) begin errors++; $display("FAIL push_pair_empty: got %b want 0", isEmpty); end
    endtask

    task automatic test_push_pop2();
        apply(0, 1, 64'h0000000000000010, POP_TWO);
        checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL pop2_count: got %0d want 1", count); end
        checks++; if (top0 !== 64'h10) begin errors++; $display("FAIL pop2_top0: got %h want 10", top0); end
        checks++; if (top1 !== '0) begin errors++; $display("FAIL pop2_top1: got %h want 0", top1); end
    endtask

    task automatic test_underflow();
        apply(1, 0, '0, POP_NONE);
        apply(0, 0, '0, POP_ONE);
        checks++; if (count !== '0) begin errors++; $display("FAIL uf_count: got %0d want 0", count); end
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %b want 1", err_underflow); end
        apply(0, 1, 64'h9999999999999999, POP_NONE);
        checks++; if (count !== CNT_W'(1) || top0 !== 64'h9999999999999999) begin errors++; $display("FAIL uf_recover: got count=%0d top0=%h want 1 9999999999999999", count, top0); end
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
    endtask

    task automatic test_fill_overflow();
        apply(1, 0, '0, POP_NONE);
        for (int i = 1; i <= DEPTH; i++) apply(0, 1, st_word_t'(i), POP_NONE);
        checks++; if (isFull !== 1'b1 || top0 !== st_word_t'(DEPTH)) begin errors++; $display("FAIL fill: got full=%b top0=%0d want 1 %0d", isFull, top0, DEPTH); end
        apply(0, 1, 64'h1234, POP_NONE);
        checks++; if (err_overflow !== 1'b1 || count !== CNT_W'(DEPTH) || top0 !== st_word_t'(DEPTH)) begin errors++; $display("FAIL of_drop: got of=%b count=%0d top0=%0d want 1 %0d %0d", err_overflow, count, top0, DEPTH, DEPTH); end
        apply(0, 1, 64'hFFFFFFFFFFFFFFFF, POP_ONE);
        checks++; if (count !== CNT_W'(DEPTH) || top0 !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL full_replace: got count=%0d top0=%h want %0d ffffffffffffffff", count, top0, DEPTH); end
        checks++; if (top1 !== st_word_t'(DEPTH - 1)) begin errors++; $display("FAIL full_replace_top1: got %0d want %0d", top1, DEPTH - 1); end
    endtask

    task automatic test_flush();
        apply(0, 1, 64'h55, 2'd3);
        checks++; if (err_underflow !== 1'b1 || count !== CNT_W'(DEPTH)) begin errors++; $display("FAIL pop3_uf: got uf=%b count=%0d want 1 %0d", err_underflow, count, DEPTH); end
        while (q.size() > 5) apply(0, 0, '0, (q.size() - 5 >= 2) ? POP_TWO : POP_ONE);
        checks++; if (count !== CNT_W'(5) || err_overflow !== 1'b1 || err_underflow !== 1'b1) begin errors++; $display("FAIL pre_flush: got count=%0d of=%b uf=%b want 5 1 1", count, err_overflow, err_underflow); end
        apply(1, 1, 64'hDEAD, POP_NONE);
        checks++; if (count !== '0 || isEmpty !== 1'b1 || top0 !== '0) begin errors++; $display("FAIL flush_state: got count=%0d empty=%b top0=%h want 0 1 0", count, isEmpty, top0); end
        checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL flush_errs: got of=%b uf=%b want 0 0", err_overflow, err_underflow); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) apply(0, 1, st_word_t'($urandom), POP_NONE);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== '0 || isEmpty !== 1'b1 || top0 !== '0 || top1 !== '0) begin errors++; $display("FAIL async_reset: got count=%0d empty=%b top0=%h top1=%h want 0 1 0 0", count, isEmpty, top0, top1); end
        q.delete(); m_uf = 1'b0; m_of = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        apply(0, 1, 64'hC0FFEE, POP_NONE);
        checks++; if (count !== CNT_W'(1) || top0 !== 64'hC0FFEE) begin errors++; $display("FAIL post_reset_push: got count=%0d top0=%h want 1 c0ffee", count, top0); end
    endtask

    task automatic test_random();
        st_word_t e0, e1;
        for (int n = 0; n < 600; n++) begin
            logic f, p;
            logic [1:0] pn;
            int r;
            f  = ($urandom_range(0, 59) == 0);
            p  = ($urandom_range(0, 99) < ((n % 200) < 100 ? 75 : 35));
            r  = $urandom_range(0, 19);
            pn = (r < 9) ? 2'd0 : (r < 15) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            apply(f, p, {$urandom, $urandom}, pn);
            e0 = (q.size() >= 1) ? q[q.size() - 1] : '0;
            e1 = (q.size() >= 2) ? q[q.size() - 2] : '0;
            checks++; if (count !== CNT_W'(q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, count, q.size()); end
            checks++; if (top0 !== e0 || top1 !== e1) begin errors++; $display("FAIL rnd_tops[%0d]: got %h %h want %h %h", n, top0, top1, e0, e1); end
            checks++; if (isEmpty !== (q.size() == 0) || isFull !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_flags[%0d]: got empty=%b full=%b want %b %b", n, isEmpty, isFull, q.size() == 0, q.size() == DEPTH); end
            checks++; if (err_overflow !== m_of || err_underflow !== m_uf) begin errors++; $display("FAIL rnd_errs[%0d]: got of=%b uf=%b want %b %b", n, err_overflow, err_underflow, m_of, m_uf); end
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_push_pair();
        test_push_pop2();
        test_underflow();
        test_fill_overflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
